// File: rtl/pulse_stretcher.sv
// pulse_stretcher: turns single-cycle request strobes into visible output
// windows of HIGH_CYCLES clocks, each followed by a LOW_CYCLES gap.
// Ports:
//   clk        - rising-edge clock
//   rst        - synchronous active-high reset
//   pulse_in   - request strobe; every high cycle is one request
//   signal_out - stretched output (active level = ~INVERT_LOGIC)
//   busy       - high while not IDLE
//   pending    - queued requests not yet rendered (saturating)
//   overflow   - one-cycle pulse when a request is dropped at saturation
module pulse_stretcher #(
    parameter bit          INVERT_LOGIC  = 1'b0,
    parameter int unsigned HIGH_CYCLES   = 5000,
    parameter int unsigned LOW_CYCLES    = 5000,
    parameter int unsigned PENDING_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pulse_in,
    output logic                     signal_out,
    output logic                     busy,
    output logic [PENDING_WIDTH-1:0] pending,
    output logic                     overflow
);

    localparam int unsigned MAXC =
        (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
    localparam int unsigned CW = $clog2(MAXC) + 1;

    localparam logic [CW-1:0] H_LAST = CW'(HIGH_CYCLES - 1);
    localparam logic [CW-1:0] L_LAST = CW'(LOW_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HIGH,
        S_GAP
    } state_e;

    state_e                   state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [PENDING_WIDTH-1:0] pend_q, pend_d;
    logic                     ovf_q, ovf_d;
    logic                     sig_q, sig_d;
    logic                     busy_q, busy_d;

    logic pend_full;
    logic pend_nz;

    assign pend_full = (pend_q == {PENDING_WIDTH{1'b1}});
    assign pend_nz   = (pend_q != '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        ovf_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // Request is consumed directly; nothing is queued.
                if (pulse_in) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                end
            end
            S_HIGH: begin
                if (cnt_q == H_LAST) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
                if (pulse_in) begin
                    if (pend_full) ovf_d  = 1'b1;
                    else           pend_d = pend_q + PENDING_WIDTH'(1);
                end
            end
            S_GAP: begin
                if (cnt_q == L_LAST) begin
                    cnt_d = '0;
                    // A strobe landing on the gap-end edge starts the next
                    // window itself, so it cancels the dequeue (net zero)
                    // and can never overflow.
                    if (pend_nz || pulse_in) begin
                        state_d = S_HIGH;
                        if (pend_nz && !pulse_in)
                            pend_d = pend_q - PENDING_WIDTH'(1);
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (pulse_in) begin
                        if (pend_full) ovf_d  = 1'b1;
                        else           pend_d = pend_q + PENDING_WIDTH'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are derived from the next state so they register in step
    // with the state itself.
    always_comb begin
        sig_d  = (state_d == S_HIGH) ? ~INVERT_LOGIC : INVERT_LOGIC;
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
            sig_q   <= INVERT_LOGIC;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            sig_q   <= sig_d;
            busy_q  <= busy_d;
        end
    end

    assign signal_out = sig_q;
    assign busy       = busy_q;
    assign pending    = pend_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// tb_pulse_stretcher: directed, table-driven checks of pulse_stretcher
// with HIGH=3, LOW=2, PENDING_WIDTH=2, plus an inverted-polarity instance.
module tb_pulse_stretcher;

    logic       clk = 1'b0;
    logic       rst0, pulse0, s0, b0, o0;
    logic [1:0] p0;
    logic       rst1, pulse1, s1, b1, o1;
    logic [1:0] p1;

    int tests  = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pulse_stretcher #(
        .INVERT_LOGIC (1'b0),
        .HIGH_CYCLES  (3),
        .LOW_CYCLES   (2),
        .PENDING_WIDTH(2)
    ) dut0 (
        .clk       (clk),
        .rst       (rst0),
        .pulse_in  (pulse0),
        .signal_out(s0),
        .busy      (b0),
        .pending   (p0),
        .overflow  (o0)
    );

    pulse_stretcher #(
        .INVERT_LOGIC (1'b1),
        .HIGH_CYCLES  (3),
        .LOW_CYCLES   (2),
        .PENDING_WIDTH(2)
    ) dut1 (
        .clk       (clk),
        .rst       (rst1),
        .pulse_in  (pulse1),
        .signal_out(s1),
        .busy      (b1),
        .pending   (p1),
        .overflow  (o1)
    );

    typedef struct {
        bit       r;
        bit       p;
        bit       es;
        bit       eb;
        bit [1:0] ep;
        bit       eo;
    } vec_t;

    vec_t tbl[$];

    task automatic v(input bit r, input bit p, input bit es,
                     input bit eb, input bit [1:0] ep, input bit eo);
        vec_t t;
        t.r  = r;
        t.p  = p;
        t.es = es;
        t.eb = eb;
        t.ep = ep;
        t.eo = eo;
        tbl.push_back(t);
    endtask

    task automatic chk(input string nm, input int idx,
                       input logic [1:0] got, input logic [1:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @%0d: got %0d, expected %0d",
                     nm, idx, got, exp);
        end
    endtask

    task automatic step1(input bit r, input bit p, input int idx,
                         input bit es, input bit eb, input bit [1:0] ep,
                         input bit eo);
        @(negedge clk);
        rst1   = r;
        pulse1 = p;
        @(posedge clk);
        #1;
        chk("inv.sig", idx, {1'b0, s1}, {1'b0, es});
        chk("inv.busy", idx, {1'b0, b1}, {1'b0, eb});
        chk("inv.pend", idx, p1, ep);
        chk("inv.ovf", idx, {1'b0, o1}, {1'b0, eo});
    endtask

    initial begin
        rst0   = 1'b1;
        pulse0 = 1'b0;
        rst1   = 1'b1;
        pulse1 = 1'b0;

        // reset, pulse_in toggled during reset
        v(1, 1, 0, 0, 0, 0);
        v(1, 0, 0, 0, 0, 0);
        v(1, 1, 0, 0, 0, 0);
        v(0, 0, 0, 0, 0, 0);
        // single strobe
        v(0, 1, 1, 1, 0, 0);
        v(0, 0, 1, 1, 0, 0);
        v(0, 0, 1, 1, 0, 0);
        v(0, 0, 0, 1, 0, 0);
        v(0, 0, 0, 1, 0, 0);
        v(0, 0, 0, 0, 0, 0);
        v(0, 0, 0, 0, 0, 0);
        // two back-to-back strobes
        v(0, 1, 1, 1, 0, 0);
        v(0, 1, 1, 1, 1, 0);
        v(0, 0, 1, 1, 1, 0);
        v(0, 0, 0, 1, 1, 0);
        v(0, 0, 0, 1, 1, 0);
        v(0, 0, 1, 1, 0, 0);
        v(0, 0, 1, 1, 0, 0);
        v(0, 0, 1, 1, 0, 0);
        v(0, 0, 0, 1, 0, 0);
        v(0, 0, 0, 1, 0, 0);
        v(0, 0, 0, 0, 0, 0);
        // overflow: five strobes, four windows
        v(0, 1, 1, 1, 0, 0);
        v(0, 1, 1, 1, 1, 0);
        v(0, 1, 1, 1, 2, 0);
        v(0, 1, 0, 1, 3, 0);
        v(0, 1, 0, 1, 3, 1);
        v(0, 0, 1, 1, 2, 0);
        v(0, 0, 1, 1, 2, 0);
        v(0, 0, 1, 1, 2, 0);
        v(0, 0, 0, 1, 2, 0);
        v(0, 0, 0, 1, 2, 0);
        v(0, 0, 1, 1, 1, 0);
        v(0, 0, 1, 1, 1, 0);
        v(0, 0, 1, 1, 1, 0);
        v(0, 0, 0, 1, 1, 0);
        v(0, 0, 0, 1, 1, 0);
        v(0, 0, 1, 1, 0, 0);
        v(0, 0, 1, 1, 0, 0);
        v(0, 0, 1, 1, 0, 0);
        v(0, 0, 0, 1, 0, 0);
        v(0, 0, 0, 1, 0, 0);
        v(0, 0, 0, 0, 0, 0);
        // strobe coincident with dequeue, pending=1
        v(0, 1, 1, 1, 0, 0);
        v(0, 1, 1, 1, 1, 0);
        v(0, 0, 1, 1, 1, 0);
        v(0, 0, 0, 1, 1, 0);
        v(0, 0, 0, 1, 1, 0);
        v(0, 1, 1, 1, 1, 0);
        v(0, 0, 1, 1, 1, 0);
        v(0, 0, 1, 1, 1, 0);
        v(0, 0, 0, 1, 1, 0);
        v(0, 0, 0, 1, 1, 0);
        v(0, 0, 1, 1, 0, 0);
        v(0, 0, 1, 1, 0, 0);
        v(0, 0, 1, 1, 0, 0);
        v(0, 0, 0, 1, 0, 0);
        v(0, 0, 0, 1, 0, 0);
        v(0, 0, 0, 0, 0, 0);
        // strobe coincident with dequeue at saturation
        v(0, 1, 1, 1, 0, 0);
        v(0, 1, 1, 1, 1, 0);
        v(0, 1, 1, 1, 2, 0);
        v(0, 1, 0, 1, 3, 0);
        v(0, 0, 0, 1, 3, 0);
        v(0, 1, 1, 1, 3, 0);
        v(0, 0, 1, 1, 3, 0);
        // reset mid-window with a full queue
        v(1, 1, 0, 0, 0, 0);
        v(0, 0, 0, 0, 0, 0);

        foreach (tbl[i]) begin
            @(negedge clk);
            rst0   = tbl[i].r;
            pulse0 = tbl[i].p;
            @(posedge clk);
            #1;
            chk("sig", i, {1'b0, s0}, {1'b0, tbl[i].es});
            chk("busy", i, {1'b0, b0}, {1'b0, tbl[i].eb});
            chk("pend", i, p0, tbl[i].ep);
            chk("ovf", i, {1'b0, o0}, {1'b0, tbl[i].eo});
        end

        // inverted polarity, reset in the 2nd HIGH cycle
        step1(1, 0, 0, 1, 0, 0, 0);
        step1(0, 0, 1, 1, 0, 0, 0);
        step1(0, 1, 2, 0, 1, 0, 0);
        step1(0, 1, 3, 0, 1, 1, 0);
        step1(1, 1, 4, 1, 0, 0, 0);
        step1(0, 0, 5, 1, 0, 0, 0);
        step1(0, 1, 6, 0, 1, 0, 0);
        step1(0, 0, 7, 0, 1, 0, 0);
        step1(0, 0, 8, 0, 1, 0, 0);
        step1(0, 0, 9, 1, 1, 0, 0);
        step1(0, 0, 10, 1, 1, 0, 0);
        step1(0, 0, 11, 1, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
